// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_MEM  = 1'b0;
  localparam logic PORT_DBG  = 1'b1;
  localparam int   MEM_DEPTH = 8192;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshake and memory command/response bus of the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              rerr;

  logic              mem_readEN;
  logic              mem_writeEn;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  // Arbiter side: takes requests and memory responses, drives grants and commands.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, rerr,
    output mem_readEN, mem_writeEn, mem_addr, mem_wdata,
    input  mem_rdata, mem_err
  );

  // Environment side: requesters plus the data memory.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, rerr,
    input  mem_readEN, mem_writeEn, mem_addr, mem_wdata,
    output mem_rdata, mem_err
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not own the previous transaction.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner,
  output logic any_req
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    winner  = PORT_MEM;
    any_req = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the memory
// stage (port 0) and the loader/debug port (port 1), one transaction at a time.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic           busy
);

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              cur_we;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rerr_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              winner;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign sel_we    = winner ? bus.we1    : bus.we0;
  assign sel_addr  = winner ? bus.addr1  : bus.addr0;
  assign sel_wdata = winner ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= PORT_MEM;
      last_owner <= PORT_DBG;
      cur_we     <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // sees the pre-edge values; the pulse defaults below are then overridden
      // by the branch that fires this cycle.
      gnt_q    <= '0;
      rvalid_q <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner         <= winner;
            last_owner    <= winner;
            cur_we        <= sel_we;
            addr_q        <= sel_addr;
            wdata_q       <= sel_wdata;
            rd_en_q       <= ~sel_we;
            wr_en_q       <= sel_we;
            gnt_q[winner] <= 1'b1;
            state         <= CMD;
          end
        end
        CMD: begin
          // The memory samples the enables on this edge; drop them right after.
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          state   <= RESP;
        end
        RESP: begin
          rdata_q         <= cur_we ? '0 : bus.mem_rdata;
          rerr_q          <= bus.mem_err;
          rvalid_q[owner] <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0        = gnt_q[PORT_MEM];
  assign bus.gnt1        = gnt_q[PORT_DBG];
  assign bus.rvalid0     = rvalid_q[PORT_MEM];
  assign bus.rvalid1     = rvalid_q[PORT_DBG];
  assign bus.rdata       = rdata_q;
  assign bus.rerr        = rerr_q;
  assign bus.mem_readEN  = rd_en_q;
  assign bus.mem_writeEn = wr_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// two-port traffic against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct {
    logic          v;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic mon_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  // Preset memory contents; word 5 holds 0xABCD.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 64'd5) return 64'hABCD;
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  // Data memory: registered read data and error flag, 8192 words.
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  always @(posedge clk) begin
    if (bus.mem_writeEn) begin
      if (bus.mem_addr < 64'(MEM_DEPTH)) mem_arr[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata <= '0;
      bus.mem_err   <= (bus.mem_addr >= 64'(MEM_DEPTH));
    end else if (bus.mem_readEN) begin
      if (bus.mem_addr >= 64'(MEM_DEPTH))
        bus.mem_rdata <= '0;
      else if (mem_arr.exists(bus.mem_addr))
        bus.mem_rdata <= mem_arr[bus.mem_addr];
      else
        bus.mem_rdata <= init_val(bus.mem_addr);
      bus.mem_err <= (bus.mem_addr >= 64'(MEM_DEPTH));
    end
  end

  // Reference model: expected memory image and round-robin history.
  logic [DW-1:0] exp_mem [logic [AW-1:0]];
  logic          exp_last;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a >= 64'(MEM_DEPTH)) return '0;
    if (exp_mem.exists(a)) return exp_mem[a];
    return init_val(a);
  endfunction

  function automatic logic exp_err(input logic [AW-1:0] a);
    return a >= 64'(MEM_DEPTH);
  endfunction

  // Exclusivity holds on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ((bus.mem_readEN && bus.mem_writeEn) || (bus.gnt0 && bus.gnt1) ||
          (bus.rvalid0 && bus.rvalid1)) begin
        bad++;
        $display("FAIL exclusive t=%0t en=%b%b gnt=%b%b rvalid=%b%b want no pair high",
                 $time, bus.mem_readEN, bus.mem_writeEn, bus.gnt0, bus.gnt1,
                 bus.rvalid0, bus.rvalid1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_port(input logic p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == PORT_MEM) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One lone-requester transaction, started at a negedge with the arbiter idle.
  task automatic do_txn(input logic p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int   waited = 0;
    logic got = 1'b0;
    logic [DW-1:0] want;
    drive_port(p, 1'b1, w, a, d);
    while (!got && waited < 6) begin
      @(negedge clk);
      waited++;
      got = p ? bus.gnt1 : bus.gnt0;
    end
    drive_port(p, 1'b0, w, a, d);
    total++;
    if (!got || waited != 1) begin
      bad++;
      $display("FAIL gnt_latency port=%0d got=%b cycles=%0d want 1", p, got, waited);
    end
    total++;
    if ({bus.mem_readEN, bus.mem_writeEn, bus.mem_addr, bus.mem_wdata} !== {~w, w, a, d}) begin
      bad++;
      $display("FAIL cmd port=%0d rd=%b wr=%b addr=%h wdata=%h want rd=%b wr=%b addr=%h wdata=%h",
               p, bus.mem_readEN, bus.mem_writeEn, bus.mem_addr, bus.mem_wdata, ~w, w, a, d);
    end
    exp_last = p;
    @(negedge clk);
    total++;
    if ({busy, bus.rvalid0, bus.rvalid1, bus.mem_readEN, bus.mem_writeEn} !== 5'b10000) begin
      bad++;
      $display("FAIL resp_phase busy=%b rvalid=%b%b en=%b%b want busy=1 others 0",
               busy, bus.rvalid0, bus.rvalid1, bus.mem_readEN, bus.mem_writeEn);
    end
    @(negedge clk);
    want = w ? '0 : exp_read(a);
    total++;
    if ({bus.rvalid1, bus.rvalid0} !== (p ? 2'b10 : 2'b01) || bus.rdata !== want ||
        bus.rerr !== exp_err(a) || busy !== 1'b0) begin
      bad++;
      $display("FAIL completion port=%0d rvalid=%b%b rdata=%h rerr=%b busy=%b want rdata=%h rerr=%b",
               p, bus.rvalid1, bus.rvalid0, bus.rdata, bus.rerr, busy, want, exp_err(a));
    end
    if (w && a < 64'(MEM_DEPTH)) exp_mem[a] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata, bus.rerr, busy,
         bus.mem_readEN, bus.mem_writeEn, bus.mem_addr, bus.mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_state gnt=%b%b rvalid=%b%b rdata=%h rerr=%b busy=%b en=%b%b addr=%h want all 0",
               bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata, bus.rerr, busy,
               bus.mem_readEN, bus.mem_writeEn, bus.mem_addr);
    end
    reset = 1'b0;
    exp_last = PORT_DBG;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_port0();
    do_txn(PORT_MEM, 1'b0, 64'd5, 64'h0);
  endtask

  task automatic test_write_read();
    do_txn(PORT_DBG, 1'b1, 64'd10, 64'h1234);
    do_txn(PORT_MEM, 1'b0, 64'd10, 64'h0);
  endtask

  task automatic test_error();
    do_txn(PORT_MEM, 1'b0, 64'd9000, 64'h0);
    do_txn(PORT_DBG, 1'b0, 64'd7, 64'h0);
  endtask

  // Both ports hold req: grants alternate every third cycle.
  task automatic test_ties();
    logic          exp_w;
    logic          own = 1'b0;
    logic [1:0]    want_g;
    logic [1:0]    want_r;
    logic [DW-1:0] want_d;
    drive_port(PORT_MEM, 1'b1, 1'b0, 64'd5, 64'h0);
    drive_port(PORT_DBG, 1'b1, 1'b0, 64'd10, 64'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      want_g = 2'b00;
      want_r = 2'b00;
      if (c % 3 == 1) begin
        exp_w    = ~exp_last;
        exp_last = exp_w;
        own      = exp_w;
        want_g   = exp_w ? 2'b10 : 2'b01;
      end else if (c % 3 == 0) begin
        want_r = own ? 2'b10 : 2'b01;
      end
      total++;
      if ({bus.gnt1, bus.gnt0} !== want_g || {bus.rvalid1, bus.rvalid0} !== want_r) begin
        bad++;
        $display("FAIL tie_cycle c=%0d gnt=%b%b rvalid=%b%b want gnt=%b rvalid=%b",
                 c, bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, want_g, want_r);
      end
      if (c % 3 == 0) begin
        want_d = exp_read(own ? 64'd10 : 64'd5);
        total++;
        if (bus.rdata !== want_d || bus.rerr !== 1'b0) begin
          bad++;
          $display("FAIL tie_data c=%0d rdata=%h rerr=%b want %h 0", c, bus.rdata, bus.rerr, want_d);
        end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d = 64'hDEAD_BEEF_0BAD_F00D;
    drive_port(PORT_MEM, 1'b1, 1'b1, 64'd20, d);
    @(negedge clk);
    total++;
    if (bus.gnt0 !== 1'b1 || bus.mem_writeEn !== 1'b1) begin
      bad++;
      $display("FAIL mid_gnt gnt0=%b wr=%b want 1 1", bus.gnt0, bus.mem_writeEn);
    end
    bus.req0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata, bus.rerr, busy,
         bus.mem_readEN, bus.mem_writeEn, bus.mem_addr, bus.mem_wdata} !== '0) begin
      bad++;
      $display("FAIL mid_reset_state rvalid=%b%b busy=%b en=%b%b addr=%h want all 0",
               bus.rvalid0, bus.rvalid1, busy, bus.mem_readEN, bus.mem_writeEn, bus.mem_addr);
    end
    reset = 1'b0;
    exp_last = PORT_DBG;
    exp_mem[64'd20] = d;
    @(negedge clk);
    total++;
    if (bus.rvalid0 !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_rvalid rvalid0=%b busy=%b want 0 0", bus.rvalid0, busy);
    end
    drive_port(PORT_MEM, 1'b1, 1'b0, 64'd20, 64'h0);
    drive_port(PORT_DBG, 1'b1, 1'b0, 64'd5, 64'h0);
    @(negedge clk);
    total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
      bad++;
      $display("FAIL post_reset_tie gnt=%b%b want 01", bus.gnt1, bus.gnt0);
    end
    exp_last = PORT_MEM;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata !== exp_read(64'd20)) begin
      bad++;
      $display("FAIL post_reset_read rvalid0=%b rdata=%h want 1 %h",
               bus.rvalid0, bus.rdata, exp_read(64'd20));
    end
  endtask

  task automatic test_busy_ignore();
    logic g1_seen = 1'b0;
    drive_port(PORT_MEM, 1'b1, 1'b0, 64'd5, 64'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      g1_seen |= bus.gnt1;
      if (c == 1) begin
        total++;
        if (bus.gnt0 !== 1'b1) begin
          bad++;
          $display("FAIL busy_gnt0 gnt0=%b want 1", bus.gnt0);
        end
        exp_last = PORT_MEM;
        bus.req0 = 1'b0;
        drive_port(PORT_DBG, 1'b1, 1'b0, 64'd10, 64'h0);
      end
      if (c == 3) begin
        total++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata !== exp_read(64'd5)) begin
          bad++;
          $display("FAIL busy_read rvalid0=%b rdata=%h want 1 %h",
                   bus.rvalid0, bus.rdata, exp_read(64'd5));
        end
        bus.req1 = 1'b0;
      end
    end
    total++;
    if (g1_seen !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore gnt1_seen=%b want 0", g1_seen);
    end
  endtask

  // Random two-port traffic; a losing requester keeps req high until granted.
  task automatic test_random();
    txn_t          pend [2];
    logic          win;
    txn_t          cur;
    logic [DW-1:0] want;
    for (int p = 0; p < 2; p++) pend[p].v = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p].v && ($urandom_range(0, 1) == 1)) begin
          pend[p].v = 1'b1;
          pend[p].w = 1'($urandom_range(0, 1));
          pend[p].a = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(8192, 20000))
                                                  : 64'($urandom_range(0, 63));
          pend[p].d = {$urandom, $urandom};
        end
      end
      if (!pend[0].v && !pend[1].v) begin
        pend[0].v = 1'b1; pend[0].w = 1'b0; pend[0].a = 64'($urandom_range(0, 63)); pend[0].d = '0;
      end
      for (int p = 0; p < 2; p++) drive_port(1'(p), pend[p].v, pend[p].w, pend[p].a, pend[p].d);
      win = (pend[0].v && pend[1].v) ? ~exp_last : pend[1].v;
      cur = pend[win];
      @(negedge clk);
      total++;
      if ({bus.gnt1, bus.gnt0} !== (win ? 2'b10 : 2'b01) ||
          {bus.mem_readEN, bus.mem_writeEn, bus.mem_addr} !== {~cur.w, cur.w, cur.a}) begin
        bad++;
        $display("FAIL rand_grant it=%0d gnt=%b%b en=%b%b addr=%h want port=%0d we=%b addr=%h",
                 it, bus.gnt1, bus.gnt0, bus.mem_readEN, bus.mem_writeEn, bus.mem_addr,
                 win, cur.w, cur.a);
      end
      exp_last = win;
      pend[win].v = 1'b0;
      drive_port(win, 1'b0, cur.w, cur.a, cur.d);
      repeat (2) @(negedge clk);
      want = cur.w ? '0 : exp_read(cur.a);
      total++;
      if ({bus.rvalid1, bus.rvalid0} !== (win ? 2'b10 : 2'b01) || bus.rdata !== want ||
          bus.rerr !== exp_err(cur.a)) begin
        bad++;
        $display("FAIL rand_resp it=%0d rvalid=%b%b rdata=%h rerr=%b want port=%0d rdata=%h rerr=%b",
                 it, bus.rvalid1, bus.rvalid0, bus.rdata, bus.rerr, win, want, exp_err(cur.a));
      end
      if (cur.w && cur.a < 64'(MEM_DEPTH)) exp_mem[cur.a] = cur.d;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive_port(PORT_MEM, 1'b0, 1'b0, '0, '0);
    drive_port(PORT_DBG, 1'b0, 1'b0, '0, '0);
    exp_last = PORT_DBG;
    @(negedge clk);
    test_reset();
    test_read_port0();
    test_write_read();
    test_error();
    test_ties();
    @(negedge clk);
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-port 64-bit data memory between two requesters: port 0 is the processor memory stage and port 1 is the program loader/debug port. It accepts one transaction at a time over a req/gnt handshake and drives the memory's read/write enables, address and write data. It returns the memory's registered read data and error flag to the owning port with an rvalid pulse. The arbiter never asserts read and write enables together.

## Interface
- ADDR_W, 64, address width for requesters and memory
- DATA_W, 64, data width
- clk  in  1  rising-edge clock shared with the data memory
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request from port 0 / port 1; held until gnt seen
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle accept pulse
- rvalid0 / rvalid1  out  1  one-cycle completion pulse to the owner
- rdata  out  DATA_W  read data (zero for writes); qualified by rvalid*
- rerr  out  1  memory error for the completed transaction; qualified by rvalid*
- busy  out  1  high when state ≠ IDLE
- mem_readEN / mem_writeEn  out  1  to memory enables
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_rdata  in  DATA_W  from memory registered read value
- mem_err  in  1  from memory registered error flag

## Operation
- FSM states: IDLE, CMD, RESP. Reset forces IDLE.
- Reset values: all outputs are 0. last_owner resets to 1, so port 0 wins the first tie.
- IDLE:
  - req* is sampled only in IDLE.
  - If exactly one port requests, it wins.
  - If both request, the port ≠ last_owner wins.
  - On the clock edge: register owner, mem_addr, mem_wdata, mem_readEN=!we, mem_writeEn=we; pulse gnt_owner; update last_owner; go to CMD.
- CMD: enables are held for exactly this cycle. On the edge: clear enables and mem_addr/mem_wdata to 0; go to RESP.
- RESP: mem_rdata and mem_err are valid. On the edge: rdata ← mem_rdata (or 0 if the transaction was a write); rerr ← mem_err; pulse rvalid_owner; go to IDLE.
- req* during CMD/RESP is ignored. A req still high when IDLE is re-entered is treated as a new transaction. Requesters drop req the cycle after gnt unless they want another access.
- Error addresses (addr > 8191) are not filtered. The arbiter forwards them and reports mem_err via rerr.
- rdata and rerr hold their value until the next completion.

## Timing
- Request seen in IDLE at cycle T: gnt at T+1, memory enables at T+1, memory captures at edge T+2, rvalid/rdata/rerr at T+3.
- IDLE is re-entered at T+3, so the next grant is at T+4 at the earliest. Throughput is one transaction per 3 cycles.
- Back-to-back ties alternate 0,1,0,1. A lone requester is granted every transaction with no starvation penalty.
- Reset mid-operation: state → IDLE and gnt/rvalid/enables clear at that edge. An enable driven in CMD during the reset cycle is still sampled by the memory at that edge; the write completes, but no rvalid is issued.
- gnt and rvalid are never high on both ports in the same cycle.

## Structure
- Package dmem_arb_pkg:
  - state enum {IDLE, CMD, RESP}
  - port index constants PORT_MEM=0, PORT_DBG=1
  - MEM_DEPTH=8192
- Sub-module rr_pick2: purely combinational. Inputs (req0, req1, last_owner); outputs winner index and any_req.
- Top contains the FSM, command registers and response registers.

## Test plan
- Read port 0: req0, we0=0, addr0=5, mem holds 0xABCD at word 5 → gnt0 @T+1, mem_readEN=1 only @T+1, rvalid0 @T+3, rdata=0xABCD, rerr=0.
- Write port 1 then read port 0: addr=10, wdata=0x1234 → rvalid1 with rdata=0; the subsequent read of addr 10 returns 0x1234.
- Ties: req0 and req1 held high continuously → grants 0,1,0,1 at T+1, T+4, T+7, T+10; no cycle with both enables high.
- Error: read at addr0=9000 → rvalid0 @T+3 with rerr=1, rdata=0; the next transaction returns rerr=0.
- Reset during CMD of a port-0 write to addr 20 → all outputs 0 the next cycle, state IDLE, no rvalid0, word 20 is written. The next request is granted to port 0 (last_owner reset to 1).
- req1 pulsed while busy (CMD/RESP) and dropped before IDLE → ignored; no gnt1.
